mc_sequencer: RTL
=================

# mc_sequencer

Multi-cycle phase sequencer for the RV32I core. It replaces the always-on `pc_en` of the single-cycle datapath with a FETCH/DECODE/EXEC/MEM/WB state machine. It gates the instruction decoder's write strobes so that each one fires only in its proper phase. It handshakes with instruction and data memory/IO, and provides run/single-step debug control plus a retired-instruction counter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles in FETCH or MEM before error. Used only with `SEQ_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rstn`: input, 1 bit. Reset, asynchronous and active-low.
- `opcode`: input, 7 bits. Bits [6:0] of the instruction register output.
- `dec_rf_we`: input, 1 bit. Decoder register-file write enable.
- `dec_dm_we`: input, 1 bit. Decoder data-memory write enable.
- `dec_io_re`: input, 1 bit. Decoder IO read enable.
- `imem_ready`: input, 1 bit. Instruction word valid this cycle.
- `mem_ready`: input, 1 bit. Data memory/IO access completes this cycle.
- `run`: input, 1 bit. Level signal; 1 selects free-running execution.
- `step`: input, 1 bit. Single-step request; its rising edge is detected internally.
- `ir_we`: output, 1 bit. Instruction register load.
- `pc_en`: output, 1 bit. PC update strobe (commit).
- `rf_we`: output, 1 bit. Gated register-file write.
- `dm_we`: output, 1 bit. Gated data-memory write.
- `io_re`: output, 1 bit. Gated IO read.
- `state`: output, 3 bits. Current state encoding.
- `busy`: output, 1 bit. High when `state` is neither IDLE nor ERR.
- `err`: output, 1 bit. Sticky error flag.
- `retired`: output, 32 bits. Count of committed instructions; wraps modulo 2^32.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7. Encoding 6 is unused and recovers to ERR.
- **IDLE**: go to FETCH if `run`=1, or on a `step` rising edge while `run`=0.
- **FETCH**: wait for `imem_ready`. `ir_we`=1 in the cycle `imem_ready`=1, then go to DECODE.
- **DECODE**: latch the instruction class from `opcode`, then branch by class:
  - 0110011, 0010011, 1101111, 1100111, 0110111, 0010111 (ALU/jump/upper) → EXEC.
  - 1100011 (branch), 0000011 (load), 0100011 (store) → EXEC.
  - 0000000 (bubble): `pc_en`=1 in DECODE, then commit.
  - Any other opcode → ERR, `err`=1, no commit.
- **EXEC**, by latched class:
  - Branch: `pc_en`=1, then commit.
  - Load/store → MEM.
  - Others → WB.
- **MEM**:
  - Load: `io_re`=`dec_io_re`, held for every MEM cycle; on `mem_ready` → WB.
  - Store: `dm_we`=`dec_dm_we`, only in the cycle `mem_ready`=1; `pc_en`=1 in that same cycle, then commit.
- **WB**: `rf_we`=`dec_rf_we` and `pc_en`=1 for one cycle, then commit.
- **Commit**: `retired` increments by 1 in the same cycle as `pc_en`. Next state is FETCH if `run`=1, otherwise IDLE.
- `step` edges while busy, or while `run`=1, are ignored and not queued.
- `run` falling mid-instruction: the instruction completes, then the block stops in IDLE.
- **ERR**: all strobes 0, `retired` frozen; exit is by reset only.
- Outside their stated phases, `rf_we`, `dm_we`, `io_re`, `ir_we` and `pc_en` are 0. They are Moore decodes of state, latched class and ready inputs.

## Timing
- Reset (asynchronous, immediate, including mid-access): state=IDLE; every strobe 0; `busy`=0, `err`=0, `retired`=0; step edge detector cleared.
- Minimum latency from FETCH entry to commit cycle, with readies high:
  - bubble: 2 cycles
  - branch: 3 cycles
  - ALU/jump/upper: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each cycle of `imem_ready`/`mem_ready` low adds one cycle.
- IDLE→FETCH: one cycle after `run`=1 or a step edge is sampled.
- Back-to-back instructions with `run`=1: FETCH follows the commit cycle with no gap.

## Configuration
- Macro `SEQ_TIMEOUT_EN`.
- **Defined**: a wait counter resets on entry to FETCH or MEM and counts each cycle with ready low. When it reaches `TIMEOUT_CYCLES`, the next state is ERR and `err`=1, with no strobes that cycle.
- **Not defined**: no counter; FETCH and MEM wait indefinitely; `TIMEOUT_CYCLES` is ignored.

## Test plan
- **ALU instruction**: reset, `run`=1, opcode 0110011, `dec_rf_we`=1, readies high → `ir_we` in cycle 1, `rf_we` and `pc_en` in cycle 4, `retired`=1.
- **Load with delayed ready**: opcode 0000011, `mem_ready` low for 3 MEM cycles → `io_re` high for 4 cycles, `rf_we` in the following WB cycle, commit latency 8.
- **Single step**: `run`=0, one `step` pulse, ALU opcode → exactly one commit, back in IDLE, `retired`=1. A second pulse issued while busy → no extra commit.
- **Illegal opcode**: opcode 1111111 → ERR after DECODE, `err`=1, `retired` unchanged, no strobes until `rstn` falls.
- **Timeout** (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): `mem_ready` held low on a store → ERR after 16 MEM cycles, `dm_we` never asserted. Without the macro → still in MEM after 1000 cycles.
- **Reset mid-access**: `rstn` low during a load's MEM state → `io_re` drops combinationally, state=IDLE, `retired`=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer for the RV32I core.
// Gates decoder write strobes by phase, handshakes with imem/dmem, run/step control,
// retired-instruction counter. Define SEQ_TIMEOUT_EN to enable the FETCH/MEM wait timeout.

module mc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic        dec_rf_we,
  input  logic        dec_dm_we,
  input  logic        dec_io_re,
  input  logic        imem_ready,
  input  logic        mem_ready,
  input  logic        run,
  input  logic        step,
  output logic        ir_we,
  output logic        pc_en,
  output logic        rf_we,
  output logic        dm_we,
  output logic        io_re,
  output logic [2:0]  state,
  output logic        busy,
  output logic        err,
  output logic [31:0] retired
);

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned RET_W  = 32;
  localparam int unsigned WAIT_W = 16;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BUBBLE = 7'b0000000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_LOAD   = 2'd2,
    CLS_STORE  = 2'd3
  } cls_e;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d, op_cls_c;
  logic               op_legal_c, op_bubble_c;
  logic               step_q, step_rise_c;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               commit_c;
  logic               wait_expired_c;

  // Out-of-range timeout values are rejected at elaboration
  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("mc_sequencer: TIMEOUT_CYCLES must be within 1..65535");
    end
  endgenerate

  assign step_rise_c = step & ~step_q;

  // Classify the opcode currently presented by the instruction register
  always_comb begin
    op_cls_c    = CLS_OTHER;
    op_legal_c  = 1'b1;
    op_bubble_c = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_cls_c = CLS_OTHER;
      OP_BRANCH: op_cls_c = CLS_BRANCH;
      OP_LOAD:   op_cls_c = CLS_LOAD;
      OP_STORE:  op_cls_c = CLS_STORE;
      OP_BUBBLE: op_bubble_c = 1'b1;
      default:   op_legal_c = 1'b0;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Timeout fires on the ready-low cycle that completes TIMEOUT_CYCLES waits
  always_comb begin
    wait_expired_c = 1'b0;
    if (state_q == S_FETCH) begin
      wait_expired_c = !imem_ready && (wait_q == WAIT_LAST);
    end else if (state_q == S_MEM) begin
      wait_expired_c = !mem_ready && (wait_q == WAIT_LAST);
    end
  end

  // Staying in FETCH/MEM implies a ready-low cycle; any state change restarts the count
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign wait_expired_c = 1'b0;
`endif

  // Next-state logic and phase-gated strobes
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    retired_d = retired_q;
    ir_we     = 1'b0;
    pc_en     = 1'b0;
    rf_we     = 1'b0;
    dm_we     = 1'b0;
    io_re     = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run || step_rise_c) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired_c) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        cls_d = op_cls_c;
        if (op_bubble_c)     commit_c = 1'b1;
        else if (op_legal_c) state_d  = S_EXEC;
        else                 state_d  = S_ERR;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          commit_c = 1'b1;
          CLS_LOAD, CLS_STORE: state_d  = S_MEM;
          default:             state_d  = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls_q == CLS_STORE) begin
          if (mem_ready) begin
            dm_we    = dec_dm_we;
            commit_c = 1'b1;
          end else if (wait_expired_c) begin
            state_d = S_ERR;
          end
        end else begin
          io_re = dec_io_re & ~wait_expired_c;
          if (mem_ready)           state_d = S_WB;
          else if (wait_expired_c) state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_we    = dec_rf_we;
        commit_c = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
    if (commit_c) begin
      pc_en     = 1'b1;
      retired_d = retired_q + RET_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  // State, class, counter and step-edge registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_OTHER;
      retired_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      step_q    <= step;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err     = (state_q == S_ERR);
  assign retired = retired_q;

endmodule
